// File: rtl/kernel_sum.sv
// Serial float32 reduction of one N-entry product kernel into the normalisation weight W_p.
// One kernel is captured per strobe; strobes that arrive while reducing are dropped and flagged.
module kernel_sum #(
    parameter int N     = 49,
    parameter int IDX_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0][31:0]  product,
    input  logic                product_valid,
    output logic [31:0]         sum,
    output logic                sum_valid,
    output logic                busy,
    output logic                overrun,
    output logic                state_dbg
);

    typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [31:0]      POS_INF  = 32'h7F80_0000;

    state_t               state_q, state_d;
    logic [N-1:0][31:0]   kbuf_q;
    logic [31:0]          acc_q, acc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [31:0]          sum_q, sum_d;
    logic                 sum_valid_q, sum_valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 load;
    logic [31:0]          add_res;

    // Unsigned truncating add: denormals are zero, exponent 255 is +inf, no NaN.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb, big_e, diff;
        logic [23:0] m_big, m_sml;
        logic [24:0] msum;
        logic [8:0]  res_e;
        logic [31:0] res;
        ea    = a[30:23];
        eb    = b[30:23];
        big_e = 8'd0;
        diff  = 8'd0;
        m_big = 24'd0;
        m_sml = 24'd0;
        msum  = 25'd0;
        res_e = 9'd0;
        res   = 32'd0;
        if (ea == 8'hFF || eb == 8'hFF) begin
            res = POS_INF;
        end else if (ea == 8'd0 && eb == 8'd0) begin
            res = 32'd0;
        end else if (ea == 8'd0) begin
            res = {1'b0, b[30:0]};
        end else if (eb == 8'd0) begin
            res = {1'b0, a[30:0]};
        end else begin
            if (ea >= eb) begin
                big_e = ea;
                diff  = ea - eb;
                m_big = {1'b1, a[22:0]};
                m_sml = {1'b1, b[22:0]};
            end else begin
                big_e = eb;
                diff  = eb - ea;
                m_big = {1'b1, b[22:0]};
                m_sml = {1'b1, a[22:0]};
            end
            m_sml = (diff >= 8'd25) ? 24'd0 : (m_sml >> diff);
            msum  = {1'b0, m_big} + {1'b0, m_sml};
            res_e = {1'b0, big_e};
            if (msum[24]) begin
                msum  = msum >> 1;
                res_e = res_e + 9'd1;
            end
            res = (res_e >= 9'd255) ? POS_INF : {1'b0, res_e[7:0], msum[22:0]};
        end
        return res;
    endfunction

    assign add_res = fadd(acc_q, kbuf_q[idx_q]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (product_valid)     state_d = S_ACC;
            S_ACC:   if (idx_q == LAST_IDX) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load        = 1'b0;
        acc_d       = acc_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        busy_d      = busy_q;
        overrun_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (product_valid) begin
                    load   = 1'b1;
                    acc_d  = 32'd0;
                    idx_d  = '0;
                    busy_d = 1'b1;
                end
            end
            S_ACC: begin
                acc_d     = add_res;
                idx_d     = idx_q + 1'b1;
                overrun_d = product_valid;
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    sum_d       = add_res;
                    sum_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // The kernel buffer needs no reset: it is always overwritten before it is read.
    always_ff @(posedge clk) begin
        if (load) begin
            kbuf_q <= product;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= 32'd0;
            idx_q       <= '0;
            sum_q       <= 32'd0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_kernel_sum.sv
// Bench for kernel_sum: driver tasks push reference sums into a queue, a negedge monitor pops
// and compares on every sum_valid, and directed tests check latency, overrun and reset abort.
module tb_kernel_sum;
    localparam int N = 49;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0][31:0] product = '0;
    logic               product_valid = 1'b0;
    logic [31:0]        sum;
    logic               sum_valid, busy, overrun, state_dbg;

    kernel_sum #(.N(N), .IDX_W(6)) dut (
        .clk(clk), .rst(rst), .product(product), .product_valid(product_valid),
        .sum(sum), .sum_valid(sum_valid), .busy(busy), .overrun(overrun),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [N-1:0][31:0] kern;
    int last_acc = -1000;
    int exp_ovr = 0;
    int ovr_cnt = 0;
    int busy_cnt = 0;
    int last_sv_cyc = -1;
    logic [31:0] last_sum = '0;
    bit mon_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference add: form the exact aligned sum as an integer, then keep its top 24 bits.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, eb_big, d, p, e;
        logic [63:0] ma, mb, s, keep;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return 32'h7F80_0000;
        if (ea == 0 && eb == 0) return 32'h0;
        if (ea == 0) return {1'b0, b[30:0]};
        if (eb == 0) return {1'b0, a[30:0]};
        if (ea >= eb) begin
            eb_big = ea; d = ea - eb;
            ma = {40'd0, 1'b1, a[22:0]}; mb = {40'd0, 1'b1, b[22:0]};
        end else begin
            eb_big = eb; d = eb - ea;
            ma = {40'd0, 1'b1, b[22:0]}; mb = {40'd0, 1'b1, a[22:0]};
        end
        if (d >= 25) mb = 64'd0;
        s = (d >= 25) ? (ma << 24) : ((ma << d) + mb);
        if (d >= 25) d = 24;
        p = 0;
        for (int i = 63; i >= 0; i--) begin
            if (s[i]) begin p = i; break; end
        end
        keep = s >> (p - 23);
        e = eb_big + (p - 23 - d);
        if (e >= 255) return 32'h7F80_0000;
        return {1'b0, 8'(e), keep[22:0]};
    endfunction

    function automatic logic [31:0] ref_kernel(input logic [N-1:0][31:0] k);
        logic [31:0] acc = 32'h0;
        for (int i = 0; i < N; i++) acc = ref_add(acc, k[i]);
        return acc;
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (busy === 1'b1) busy_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
            if (sum_valid === 1'b1) begin
                chk("sum_known", 32'($isunknown(sum)), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_sum_valid", 32'd1, 32'd0);
                end else begin
                    chk("sum", sum, exp_q.pop_front());
                end
                last_sum    = sum;
                last_sv_cyc = cyc;
            end
        end
    end

    // Drive a strobe so that it is sampled at posedge number e; the model decides acceptance.
    task automatic strobe_at(input int e);
        while (cyc < e - 1) begin @(posedge clk); #1; end
        product       = kern;
        product_valid = 1'b1;
        if (e > last_acc && e <= last_acc + N) begin
            exp_ovr++;
        end else begin
            last_acc = e;
            exp_q.push_back(ref_kernel(kern));
        end
        @(posedge clk); #1;
        product_valid = 1'b0;
        for (int i = 0; i < N; i++) product[i] = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin @(posedge clk); #1; end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        last_acc = -1000;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < N; i++) kern[i] = v;
    endtask

    task automatic fill_rand(input int big);
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 9))
                0:       kern[i] = 32'h0;
                1:       kern[i] = {9'd0, 23'($urandom)};
                default: kern[i] = big != 0 ? {1'b0, 8'($urandom_range(248, 254)), 23'($urandom)}
                                            : {1'b0, 8'($urandom_range(100, 135)), 23'($urandom)};
            endcase
        end
    endtask

    task automatic run_const(input string name, input logic [31:0] want);
        strobe_at(cyc + 1);
        drain();
        chk(name, last_sum, want);
    endtask

    initial begin
        int e0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        mon_on = 1;
        @(negedge clk);
        chk("rst_sum", sum, 32'h0);
        chk("rst_flags", {29'd0, sum_valid, busy, overrun}, 32'd0);
        @(posedge clk); #1;

        // 1.0 x 49: value, latency and busy length
        fill(32'h3F80_0000);
        busy_cnt = 0;
        e0 = cyc + 1;
        strobe_at(e0);
        drain();
        chk("ones_sum", last_sum, 32'h4244_0000);
        chk("ones_latency", 32'(last_sv_cyc), 32'(e0 + N));
        chk("ones_busy_cycles", 32'(busy_cnt), 32'(N));

        fill(32'h3F00_0000);
        run_const("halves_sum", 32'h41C4_0000);
        fill(32'h0);
        run_const("zeros_sum", 32'h0);
        fill(32'h0);
        kern[24] = 32'h4040_0000;
        run_const("single_three", 32'h4040_0000);
        fill(32'h0000_0001);
        run_const("denormals", 32'h0);
        fill(32'h7F00_0000);
        run_const("saturate_inf", 32'h7F80_0000);

        // Strobes every 2 cycles, then one in the sum_valid cycle
        ovr_cnt = 0; exp_ovr = 0;
        e0 = cyc + 1;
        for (int s = 0; s < 5; s++) begin
            fill_rand(0);
            strobe_at(e0 + 2 * s);
        end
        fill_rand(0);
        strobe_at(e0 + N + 1);
        drain();
        chk("overrun_pulses", 32'(ovr_cnt), 32'd4);
        chk("overrun_model", 32'(ovr_cnt), 32'(exp_ovr));
        chk("sv_cycle_accept", 32'(last_sv_cyc), 32'(e0 + 2 * N + 1));

        // Reset 20 cycles into a reduction aborts it
        fill(32'h3F80_0000);
        e0 = cyc + 1;
        strobe_at(e0);
        while (cyc < e0 + 19) begin @(posedge clk); #1; end
        do_reset();
        @(negedge clk);
        chk("abort_sum", sum, 32'h0);
        chk("abort_flags", {29'd0, sum_valid, busy, overrun}, 32'd0);
        repeat (60) @(posedge clk);
        #1;
        fill(32'h3F00_0000);
        run_const("after_abort", 32'h41C4_0000);

        // Randomized kernels with random gaps; close gaps produce overruns
        ovr_cnt = 0; exp_ovr = 0;
        for (int r = 0; r < 14; r++) begin
            fill_rand(r % 5 == 4 ? 1 : 0);
            strobe_at(cyc + 1 + $urandom_range(0, 60));
        end
        drain();
        chk("rand_overruns", 32'(ovr_cnt), 32'(exp_ovr));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
